// File: rtl/msp430_gpio_port.sv
// msp430_gpio_port
// 8-bit GPIO port on the peripheral bus. The port exposes an eight-byte
// register window (IN, OUT, DIR, IFG, IES, IE, SEL, reserved), drives the
// pad-cell output value and enable, synchronises the raw pad inputs, flags
// selected pad edges in IFG and raises one registered interrupt request.
module msp430_gpio_port #(
    parameter logic [14:0] BASE_ADDR = 15'h0020,
    parameter int unsigned DEC_WD    = 3
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [7:0]  p_din,
    output logic [7:0]  p_dout,
    output logic [7:0]  p_dout_en,
    output logic [7:0]  p_sel,
    output logic        irq
);

    // Byte offsets inside the register window
    localparam int unsigned OFS_OUT = 1;
    localparam int unsigned OFS_DIR = 2;
    localparam int unsigned OFS_IFG = 3;
    localparam int unsigned OFS_IES = 4;
    localparam int unsigned OFS_IE  = 5;
    localparam int unsigned OFS_SEL = 6;

    // Number of 16-bit words holding the eight defined byte registers
    localparam int unsigned NUM_WORDS = 4;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [7:0] sync_s1;
    logic [7:0] sync_s2;
    logic [7:0] in_dly;
    logic [7:0] out_reg;
    logic [7:0] dir_reg;
    logic [7:0] ifg_reg;
    logic [7:0] ies_reg;
    logic [7:0] ie_reg;
    logic [7:0] sel_reg;
    logic       irq_reg;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                reg_sel;
    logic [DEC_WD-2:0]   word_idx;
    logic [6:1]          byte_wr;
    logic [7:0]          wr_lo;
    logic [7:0]          wr_hi;

    assign reg_sel  = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign word_idx = per_addr[DEC_WD-2:0];
    assign wr_lo    = per_din[7:0];
    assign wr_hi    = per_din[15:8];

    // Per-byte write strobes: even offsets use the low lane, odd the high lane.
    // IN (offset 0) and the reserved byte (offset 7) have no strobe at all.
    always_comb begin
        byte_wr = '0;
        for (int unsigned i = 1; i <= 6; i++) begin
            if (reg_sel && (word_idx == (DEC_WD-1)'(i >> 1)) && per_we[i[0]]) begin
                byte_wr[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pad input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [7:0] rise_evt;
    logic [7:0] fall_evt;
    logic [7:0] pin_evt;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            in_dly  <= '0;
        end else begin
            sync_s1 <= p_din;
            sync_s2 <= sync_s1;
            in_dly  <= sync_s2;
        end
    end

    // Select the rising or falling edge per bit according to IES
    always_comb begin
        rise_evt = ~in_dly & sync_s2;
        fall_evt = in_dly & ~sync_s2;
        pin_evt  = (ies_reg & fall_evt) | (~ies_reg & rise_evt);
    end

    // ------------------------------------------------------------------
    // Software-written configuration registers
    // ------------------------------------------------------------------

    // Bus writes to OUT, DIR, IES, IE and SEL
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            out_reg <= '0;
            dir_reg <= '0;
            ies_reg <= '0;
            ie_reg  <= '0;
            sel_reg <= '0;
        end else begin
            if (byte_wr[OFS_OUT]) out_reg <= wr_hi;
            if (byte_wr[OFS_DIR]) dir_reg <= wr_lo;
            if (byte_wr[OFS_IES]) ies_reg <= wr_lo;
            if (byte_wr[OFS_IE])  ie_reg  <= wr_hi;
            if (byte_wr[OFS_SEL]) sel_reg <= wr_lo;
        end
    end

    // Interrupt flags: a detected edge sets the flag even when software
    // clears it in the same cycle; software may also set flags directly.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ifg_reg <= '0;
        end else begin
            ifg_reg <= pin_evt | (byte_wr[OFS_IFG] ? wr_hi : ifg_reg);
        end
    end

    // Registered interrupt request from enabled pending flags
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(ifg_reg & ie_reg);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [8*2*NUM_WORDS-1:0] rd_bytes;
    logic [15:0]              rd_word;

    // Byte offset n of the window lives at rd_bytes[8n +: 8]
    assign rd_bytes = {8'h00, sel_reg, ie_reg, ies_reg,
                       ifg_reg, dir_reg, out_reg, sync_s2};

    // Combinational word select; words past the defined map read zero
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (word_idx == (DEC_WD-1)'(k)) begin
                rd_word = rd_bytes[16*k +: 16];
            end
        end
        per_dout = (reg_sel && (per_we == 2'b00)) ? rd_word : '0;
    end

    // ------------------------------------------------------------------
    // Pad and interrupt outputs straight from registers
    // ------------------------------------------------------------------
    assign p_dout    = out_reg;
    assign p_dout_en = dir_reg;
    assign p_sel     = sel_reg;
    assign irq       = irq_reg;

endmodule
